hazard_stall_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage MIPS pipeline.
- Compares the ID-stage instruction's source-register use time (Tuse) against each in-flight EX/MEM producer's result-ready time (Tnew).
- Owns the busy counter of the multi-cycle mult/div unit and blocks HI/LO-dependent instructions while that unit runs.
- Drives the hold input of the IF/ID register, the PC enable, and the bubble-insert (flush) of ID/EX.

---
 rtl/hazard_stall_ctrl_pkg.sv | 21 ++
 rtl/hazard_stall_ctrl_md_busy_counter.sv | 43 ++++
 rtl/hazard_stall_ctrl.sv | 82 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
package hazard_stall_ctrl_pkg;

  typedef logic [4:0] reg_addr_t;
  typedef logic [1:0] stage_time_t;

  // Tuse of 3 marks a source operand the ID instruction does not read.
  localparam stage_time_t TUSE_NONE = 2'd3;

  // Tnew of 0 means the producer result can already be forwarded.
  localparam stage_time_t TNEW_READY = 2'd0;

  // Register $0 is hardwired and never creates a dependency.
  localparam reg_addr_t REG_ZERO = 5'd0;

  // Default mult/div unit latencies and busy counter width.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Busy counter for the multi-cycle mult/div unit, with a one-cycle done pulse.
module md_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy,
  output logic o_done
);

  localparam logic [CNT_W-1:0] LP_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] LP_DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LP_ONE       = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  // Load on start (a new start reloads), otherwise count down and stop at zero;
  // done is raised for the cycle right after the counter leaves 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (i_start) begin
        r_cnt <= i_is_div ? LP_DIV_LOAD : LP_MULT_LOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - LP_ONE;
      end
      r_done <= (r_cnt == LP_ONE) && !i_start;
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = r_done;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: compares ID operand Tuse against EX/MEM producer Tnew
// and blocks HI/LO users while the mult/div unit is occupied.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_tuse_rs,
  input  logic [1:0] id_tuse_rt,
  input  logic       id_uses_hilo,
  input  logic [4:0] ex_wa,
  input  logic [1:0] ex_tnew,
  input  logic [4:0] mem_wa,
  input  logic [1:0] mem_tnew,
  input  logic       ex_md_start,
  input  logic       ex_md_is_div,
  output logic       stall,
  output logic       pc_en,
  output logic       flush_id_ex,
  output logic       md_busy,
  output logic       md_done
);

  logic w_hz_rs;
  logic w_hz_rt;
  logic w_hz_md;
  logic w_md_busy;
  logic w_md_done;

  // A source stalls when a matching producer in EX or MEM will not have its
  // result ready by the time ID needs it. Each stage is checked on its own.
  function automatic logic src_hazard(
    input reg_addr_t   addr,
    input stage_time_t tuse,
    input reg_addr_t   e_wa,
    input stage_time_t e_tnew,
    input reg_addr_t   m_wa,
    input stage_time_t m_tnew
  );
    logic l_ex;
    logic l_mem;
    l_ex  = (addr == e_wa) && (tuse < e_tnew) && (e_tnew != TNEW_READY);
    l_mem = (addr == m_wa) && (tuse < m_tnew) && (m_tnew != TNEW_READY);
    return (addr != REG_ZERO) && (tuse != TUSE_NONE) && (l_ex || l_mem);
  endfunction

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_start  (ex_md_start),
    .i_is_div (ex_md_is_div),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done)
  );

  // Same-cycle hazard detection; a start in EX already blocks HI/LO users.
  always_comb begin
    w_hz_rs = src_hazard(id_rs, id_tuse_rs, ex_wa, ex_tnew, mem_wa, mem_tnew);
    w_hz_rt = src_hazard(id_rt, id_tuse_rt, ex_wa, ex_tnew, mem_wa, mem_tnew);
    w_hz_md = id_uses_hilo && (w_md_busy || ex_md_start);
  end

  // Stall freezes PC and IF/ID and bubbles ID/EX so older stages keep draining.
  always_comb begin
    stall       = w_hz_rs || w_hz_rt || w_hz_md;
    pc_en       = !stall;
    flush_id_ex = stall;
    md_busy     = w_md_busy;
    md_done     = w_md_done;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with hand-computed expectations.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_wa, mem_wa;
  logic [1:0] id_tuse_rs, id_tuse_rt, ex_tnew, mem_tnew;
  logic       id_uses_hilo, ex_md_start, ex_md_is_div;
  logic       stall, pc_en, flush_id_ex, md_busy, md_done;

  int n_checks = 0;
  int n_errors = 0;

  hazard_stall_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_tuse_rs   (id_tuse_rs),
    .id_tuse_rt   (id_tuse_rt),
    .id_uses_hilo (id_uses_hilo),
    .ex_wa        (ex_wa),
    .ex_tnew      (ex_tnew),
    .mem_wa       (mem_wa),
    .mem_tnew     (mem_tnew),
    .ex_md_start  (ex_md_start),
    .ex_md_is_div (ex_md_is_div),
    .stall        (stall),
    .pc_en        (pc_en),
    .flush_id_ex  (flush_id_ex),
    .md_busy      (md_busy),
    .md_done      (md_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0;
    id_tuse_rs = 2'd3; id_tuse_rt = 2'd3;
    id_uses_hilo = 1'b0;
    ex_wa = 5'd0; ex_tnew = 2'd0;
    mem_wa = 5'd0; mem_tnew = 2'd0;
    ex_md_start = 1'b0; ex_md_is_div = 1'b0;
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, "_stall"}, int'(stall), int'(exp));
    chk({tag, "_pc_en"}, int'(pc_en), int'(!exp));
    chk({tag, "_flush"}, int'(flush_id_ex), int'(exp));
  endtask

  initial begin
    int busy_len;
    idle_inputs();
    reset = 1'b0;

    // Reset state, including across clock edges while reset is held.
    #2;
    chk_stall("rst", 1'b0);
    chk("rst_busy", int'(md_busy), 0);
    chk("rst_done", int'(md_done), 0);
    ex_md_start = 1'b1;
    tick(); tick();
    ex_md_start = 1'b0;
    #1;
    chk("rst_hold_busy", int'(md_busy), 0);
    reset = 1'b1;
    tick();

    // Load-use through EX, then MEM, then resolved.
    ex_wa = 5'd8; ex_tnew = 2'd2; id_rs = 5'd8; id_tuse_rs = 2'd0;
    #1;
    chk_stall("lu_ex", 1'b1);
    tick();
    ex_wa = 5'd0; ex_tnew = 2'd0; mem_wa = 5'd8; mem_tnew = 2'd1;
    #1;
    chk_stall("lu_mem", 1'b1);
    tick();
    mem_tnew = 2'd0;
    #1;
    chk_stall("lu_done", 1'b0);

    // Register zero never hazards.
    idle_inputs();
    ex_wa = 5'd0; id_rs = 5'd0; ex_tnew = 2'd2; id_tuse_rs = 2'd0;
    #1;
    chk_stall("r0", 1'b0);

    // rt: tuse equal to tnew is not a hazard, tuse below tnew is.
    idle_inputs();
    id_rt = 5'd9; id_tuse_rt = 2'd1; mem_wa = 5'd9; mem_tnew = 2'd1;
    #1;
    chk_stall("rt_eq", 1'b0);
    mem_tnew = 2'd2;
    #1;
    chk_stall("rt_mem", 1'b1);
    ex_wa = 5'd9; ex_tnew = 2'd2; mem_wa = 5'd0; mem_tnew = 2'd0;
    #1;
    chk("rt_ex_stall", int'(stall), 1);
    // Unused operand (Tuse=3) never stalls, even on a matching address.
    id_tuse_rt = 2'd3; ex_tnew = 2'd3;
    #1;
    chk("rt_unused_stall", int'(stall), 0);
    // Different address with a pending producer does not stall.
    idle_inputs();
    id_rs = 5'd7; id_tuse_rs = 2'd0; ex_wa = 5'd6; ex_tnew = 2'd2;
    #1;
    chk("addr_diff_stall", int'(stall), 0);

    // Multiply with mflo waiting in ID.
    tick();
    idle_inputs();
    id_uses_hilo = 1'b1; ex_md_start = 1'b1; ex_md_is_div = 1'b0;
    #1;
    chk("mul_start_stall", int'(stall), 1);
    chk("mul_start_busy", int'(md_busy), 0);
    tick();
    ex_md_start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk($sformatf("mul_busy%0d", i), int'(md_busy), 1);
      chk($sformatf("mul_stall%0d", i), int'(stall), 1);
      chk($sformatf("mul_done%0d", i), int'(md_done), 0);
      tick();
    end
    #1;
    chk("mul_end_busy", int'(md_busy), 0);
    chk("mul_end_done", int'(md_done), 1);
    chk_stall("mul_end", 1'b0);
    tick();
    chk("mul_done_clear", int'(md_done), 0);

    // Full divide: busy length measured with a bounded loop.
    id_uses_hilo = 1'b0; ex_md_start = 1'b1; ex_md_is_div = 1'b1;
    tick();
    ex_md_start = 1'b0; ex_md_is_div = 1'b0;
    busy_len = 0;
    for (int i = 0; i < 20 && md_busy; i++) begin
      busy_len++;
      tick();
    end
    chk("div_len", busy_len, 10);
    chk("div_done", int'(md_done), 1);
    tick();

    // Divide interrupted by reset at busy cycle 4, between clock edges.
    ex_md_start = 1'b1; ex_md_is_div = 1'b1;
    tick();
    ex_md_start = 1'b0; ex_md_is_div = 1'b0; id_uses_hilo = 1'b1;
    tick(); tick(); tick();
    #1;
    chk("divr_busy4", int'(md_busy), 1);
    chk("divr_stall4", int'(stall), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("divr_busy_async", int'(md_busy), 0);
    chk_stall("divr_async", 1'b0);
    tick();
    #2;
    reset = 1'b1;
    tick(); tick();
    chk("divr_after_busy", int'(md_busy), 0);
    chk("divr_after_done", int'(md_done), 0);
    chk("divr_after_stall", int'(stall), 0);

    // Register and HI/LO hazards together, then each removed in turn.
    idle_inputs();
    id_rs = 5'd4; id_tuse_rs = 2'd0; ex_wa = 5'd4; ex_tnew = 2'd1;
    id_uses_hilo = 1'b1; ex_md_start = 1'b1;
    #1;
    chk("both_stall", int'(stall), 1);
    ex_md_start = 1'b0;
    #1;
    chk("rs_only_stall", int'(stall), 1);
    ex_md_start = 1'b1; ex_wa = 5'd0;
    #1;
    chk("md_only_stall", int'(stall), 1);
    ex_md_start = 1'b0;
    #1;
    chk_stall("none", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
